// File: rtl/scariv_pkg.sv
// scariv_pkg: shared types for the ROB group entry.
// State encoding, exception type and the another-flush code.
package scariv_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_COMPLETE = 2'd2,
    ST_DRAIN    = 2'd3
  } grp_state_t;

  localparam int EXC_W = 4;

  typedef logic [EXC_W-1:0] except_t;

  localparam except_t ANOTHER_FLUSH = '1;

endpackage

// File: rtl/scariv_rob_commit_scan.sv
// scariv_rob_commit_scan: retirable-slot scan from the commit pointer.
// Stops after the first live excepting slot, which it reports.
module scariv_rob_commit_scan
  import scariv_pkg::*;
#(
  parameter int GRP_W    = 4,
  parameter int COMMIT_W = 2,
  localparam int SW = (GRP_W > 1) ? $clog2(GRP_W) : 1,
  localparam int PW = $clog2(GRP_W + 1),
  localparam int CW = $clog2(COMMIT_W + 1)
)(
  input  logic [GRP_W-1:0]       i_done,
  input  logic [GRP_W-1:0]       i_dead,
  input  logic [GRP_W-1:0]       i_exc_v,
  input  logic [GRP_W*EXC_W-1:0] i_exc_t,
  input  logic [PW-1:0]          i_ptr,
  output logic [CW-1:0]          o_cnt,
  output logic                   o_exc_valid,
  output logic [SW-1:0]          o_exc_slot,
  output logic [EXC_W-1:0]       o_exc_type
);

  logic w_stop;

  // walk the commit window in slot order
  always_comb begin
    o_cnt       = '0;
    o_exc_valid = 1'b0;
    o_exc_slot  = '0;
    o_exc_type  = '0;
    w_stop      = 1'b0;
    for (int s = 0; s < GRP_W; s++) begin
      if (!w_stop && s >= int'(i_ptr) &&
          s < int'(i_ptr) + COMMIT_W) begin
        if (!i_done[s]) begin
          w_stop = 1'b1;
        end else begin
          o_cnt = o_cnt + CW'(1);
          if (i_exc_v[s] && !i_dead[s]) begin
            o_exc_valid = 1'b1;
            o_exc_slot  = SW'(s);
            o_exc_type  = i_exc_t[s*EXC_W +: EXC_W];
            w_stop      = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/scariv_rob_grp_entry.sv
// scariv_rob_grp_entry: one ROB group entry.
// Tracks completion, kills and exceptions for a group of slots.
module scariv_rob_grp_entry
  import scariv_pkg::*;
#(
  parameter int GRP_W       = 4,
  parameter int DONE_PORTS  = 6,
  parameter int FLUSH_PORTS = 2,
  parameter int IDX_W       = 5,
  parameter int COMMIT_W    = 2,
  parameter int WDOG_W      = 10,
  localparam int SW = (GRP_W > 1) ? $clog2(GRP_W) : 1,
  localparam int PW = $clog2(GRP_W + 1),
  localparam int CW = $clog2(COMMIT_W + 1)
)(
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [IDX_W-1:0]              i_entry_idx,
  input  logic                          i_load_valid,
  input  logic [GRP_W-1:0]              i_load_grp,
  input  logic [DONE_PORTS-1:0]         i_done_valid,
  input  logic [DONE_PORTS*IDX_W-1:0]   i_done_idx,
  input  logic [DONE_PORTS*SW-1:0]      i_done_slot,
  input  logic [DONE_PORTS-1:0]         i_done_exc,
  input  logic [DONE_PORTS*EXC_W-1:0]   i_done_exc_type,
  input  logic [FLUSH_PORTS-1:0]        i_flush_valid,
  input  logic [FLUSH_PORTS*IDX_W-1:0]  i_flush_idx,
  input  logic [FLUSH_PORTS*SW-1:0]     i_flush_slot,
  input  logic                          i_br_valid,
  input  logic [IDX_W-1:0]              i_br_idx,
  input  logic [SW-1:0]                 i_br_slot,
  input  logic                          i_br_mispredict,
  input  logic                          i_kill,
  input  logic [CW-1:0]                 i_commit_cnt,
  output logic [1:0]                    o_state,
  output logic [GRP_W-1:0]              o_done_mask,
  output logic [GRP_W-1:0]              o_dead_mask,
  output logic [PW-1:0]                 o_cmt_ptr,
  output logic [CW-1:0]                 o_ready_cnt,
  output logic                          o_exc_valid,
  output logic [SW-1:0]                 o_exc_slot,
  output logic [EXC_W-1:0]              o_exc_type,
  output logic                          o_load_err,
  output logic                          o_timeout
);

  grp_state_t               r_state, w_state_n;
  logic [GRP_W-1:0]         r_grp, w_grp_n;
  logic [GRP_W-1:0]         r_done, w_done_n;
  logic [GRP_W-1:0]         r_dead, w_dead_n;
  logic [GRP_W-1:0]         r_exc_v, w_exc_v_n;
  except_t [GRP_W-1:0]      r_exc_t, w_exc_t_n;
  logic [PW-1:0]            r_cmt_ptr, w_ptr_n;
  logic [PW-1:0]            w_ptr_adv, w_end;
  logic [WDOG_W-1:0]        r_wdog;
  logic                     r_load_err;

  logic [GRP_W-1:0]         w_done_hit, w_done_exc;
  except_t [GRP_W-1:0]      w_done_type;
  logic [CW-1:0]            w_scan_cnt, w_ready, w_cmt_eff;
  logic                     w_scan_exc;
  logic [SW-1:0]            w_scan_slot;
  except_t                  w_scan_type;
  logic                     w_live, w_load_ok, w_kill;
  logic                     w_br_hit, w_found, w_evt;

  assign w_live    = (r_state != ST_EMPTY);
  assign w_load_ok = i_load_valid & ~w_live;
  assign w_kill    = i_kill & w_live;
  assign w_ready   = w_live ? w_scan_cnt : '0;
  assign w_cmt_eff = (!w_live || w_kill) ? '0 :
                     (i_commit_cnt > w_ready) ? w_ready :
                     i_commit_cnt;
  assign w_ptr_adv = r_cmt_ptr + PW'(w_cmt_eff);
  assign w_evt     = w_load_ok | (|w_done_hit) |
                     (w_cmt_eff != '0);

  scariv_rob_commit_scan #(
    .GRP_W    (GRP_W),
    .COMMIT_W (COMMIT_W)
  ) u_scan (
    .i_done      (r_done),
    .i_dead      (r_dead),
    .i_exc_v     (r_exc_v),
    .i_exc_t     (r_exc_t),
    .i_ptr       (r_cmt_ptr),
    .o_cnt       (w_scan_cnt),
    .o_exc_valid (w_scan_exc),
    .o_exc_slot  (w_scan_slot),
    .o_exc_type  (w_scan_type)
  );

  // one past the highest valid slot
  always_comb begin
    w_end = '0;
    for (int s = 0; s < GRP_W; s++)
      if (r_grp[s]) w_end = PW'(s + 1);
  end

  // per-slot done report; lowest port overrides
  always_comb begin
    w_done_hit  = '0;
    w_done_exc  = '0;
    w_done_type = '0;
    for (int s = 0; s < GRP_W; s++)
      for (int p = DONE_PORTS - 1; p >= 0; p--)
        if (i_done_valid[p] && w_live && r_grp[s] &&
            i_done_idx[p*IDX_W +: IDX_W] == i_entry_idx &&
            i_done_slot[p*SW +: SW] == SW'(s)) begin
          w_done_hit[s]  = 1'b1;
          w_done_exc[s]  = i_done_exc[p];
          w_done_type[s] = i_done_exc_type[p*EXC_W +: EXC_W];
        end
  end

  // mispredict against a valid slot of this entry
  always_comb begin
    w_br_hit = 1'b0;
    for (int s = 0; s < GRP_W; s++)
      if (i_br_slot == SW'(s) && r_grp[s])
        w_br_hit = i_br_valid & i_br_mispredict & w_live &
                   (i_br_idx == i_entry_idx);
  end

  // next entry contents and FSM state
  always_comb begin
    w_done_n  = r_done | w_done_hit;
    w_dead_n  = r_dead;
    w_exc_v_n = r_exc_v;
    w_exc_t_n = r_exc_t;
    w_grp_n   = r_grp;
    w_ptr_n   = w_ptr_adv;
    w_state_n = r_state;
    w_found   = 1'b0;
    for (int f = 0; f < FLUSH_PORTS; f++)
      for (int s = 0; s < GRP_W; s++)
        if (i_flush_valid[f] && w_live && r_grp[s] &&
            !r_dead[s] &&
            i_flush_idx[f*IDX_W +: IDX_W] == i_entry_idx &&
            i_flush_slot[f*SW +: SW] == SW'(s)) begin
          w_exc_v_n[s] = 1'b1;
          w_exc_t_n[s] = ANOTHER_FLUSH;
        end
    for (int s = 0; s < GRP_W; s++) begin
      if (w_found) begin
        w_done_n[s]  = 1'b1;
        w_dead_n[s]  = 1'b1;
        w_exc_v_n[s] = 1'b0;
      end else if (w_done_hit[s] && w_done_exc[s] &&
                   !r_dead[s]) begin
        w_found      = 1'b1;
        w_exc_v_n[s] = 1'b1;
        w_exc_t_n[s] = w_done_type[s];
      end
    end
    for (int s = 0; s < GRP_W; s++)
      if (w_br_hit && SW'(s) > i_br_slot) begin
        w_done_n[s]  = 1'b1;
        w_dead_n[s]  = 1'b1;
        w_exc_v_n[s] = 1'b0;
      end
    if (w_kill) begin
      w_done_n  = r_done;
      w_dead_n  = r_dead;
      w_exc_v_n = '0;
      w_exc_t_n = r_exc_t;
      w_ptr_n   = r_cmt_ptr;
      w_state_n = ST_COMPLETE;
      for (int s = 0; s < GRP_W; s++)
        if (PW'(s) >= r_cmt_ptr) begin
          w_done_n[s] = 1'b1;
          w_dead_n[s] = 1'b1;
        end
    end else if (w_live) begin
      if (w_ptr_adv >= w_end)
        w_state_n = ST_EMPTY;
      else if (r_state == ST_ACTIVE &&
               &(w_done_n | w_dead_n | ~r_grp))
        w_state_n = ST_COMPLETE;
      else if (r_state == ST_COMPLETE && w_cmt_eff != '0)
        w_state_n = ST_DRAIN;
    end
    if (w_load_ok) begin
      w_grp_n   = i_load_grp;
      w_done_n  = ~i_load_grp;
      w_dead_n  = ~i_load_grp;
      w_exc_v_n = '0;
      w_exc_t_n = '0;
      w_ptr_n   = '0;
      w_state_n = (|i_load_grp) ? ST_ACTIVE : ST_EMPTY;
    end
  end

  // entry state registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_EMPTY;
      r_grp     <= '0;
      r_done    <= '0;
      r_dead    <= '0;
      r_exc_v   <= '0;
      r_exc_t   <= '0;
      r_cmt_ptr <= '0;
    end else begin
      r_state   <= w_state_n;
      r_grp     <= w_grp_n;
      r_done    <= w_done_n;
      r_dead    <= w_dead_n;
      r_exc_v   <= w_exc_v_n;
      r_exc_t   <= w_exc_t_n;
      r_cmt_ptr <= w_ptr_n;
    end
  end

  // rejected-load pulse
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_load_err <= 1'b0;
    else         r_load_err <= i_load_valid & w_live;
  end

  // watchdog: saturating idle counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_wdog <= '0;
    else if (w_evt)
      r_wdog <= '0;
    else if (w_live && !(&r_wdog))
      r_wdog <= r_wdog + WDOG_W'(1);
  end

  assign o_state     = r_state;
  assign o_done_mask = r_done;
  assign o_dead_mask = r_dead;
  assign o_cmt_ptr   = r_cmt_ptr;
  assign o_ready_cnt = w_ready;
  assign o_exc_valid = w_live & w_scan_exc;
  assign o_exc_slot  = w_live ? w_scan_slot : '0;
  assign o_exc_type  = w_live ? w_scan_type : '0;
  assign o_load_err  = r_load_err;
  assign o_timeout   = &r_wdog;

endmodule
